// File: rtl/pc_defs.sv
// Shared control-flow definitions: branch op encodings, default reset vector
// and the condition evaluation used by the PC sequencer.
package pc_defs;

    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_JUMP = 3'd1,
        BR_BEQ  = 3'd2,
        BR_BNE  = 3'd3,
        BR_BLT  = 3'd4,
        BR_BGE  = 3'd5,
        BR_CALL = 3'd6,
        BR_RET  = 3'd7
    } br_op_e;

    localparam logic [31:0] PC_RESET_VECTOR = 32'h0000_0000;
    localparam int          INSN_BYTES      = 4;

    // RET is not "taken" here: its target comes from the return stack.
    function automatic logic br_taken(input br_op_e op, input logic zero, input logic neg);
        logic taken;
        taken = 1'b0;
        case (op)
            BR_JUMP: taken = 1'b1;
            BR_BEQ:  taken = zero;
            BR_BNE:  taken = ~zero;
            BR_BLT:  taken = neg;
            BR_BGE:  taken = ~neg;
            BR_CALL: taken = 1'b1;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack; push/pop take effect on the next rising edge,
// top-of-stack is combinational. Full pushes overwrite the oldest entry.
module ras_stack #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_dat,
    output logic [WIDTH-1:0] o_top,
    output logic [CNT_W-1:0] o_count,
    output logic             o_ovf,
    output logic             o_unf
);

    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_ovf;
    logic             r_unf;
    logic [PTR_W-1:0] w_top_ptr;

    // r_ptr is the next write slot; the newest entry sits just below it.
    assign w_top_ptr = r_ptr - PTR_W'(1);
    assign o_top     = r_mem[w_top_ptr];
    assign o_count   = r_count;
    assign o_ovf     = r_ovf;
    assign o_unf     = r_unf;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ptr   <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else if (i_push) begin
            r_ptr <= r_ptr + PTR_W'(1);
            if (r_count == FULL) begin
                r_ovf <= 1'b1;
            end else begin
                r_count <= r_count + CNT_W'(1);
            end
        end else if (i_pop) begin
            if (r_count == '0) begin
                r_unf <= 1'b1;
            end else begin
                r_ptr   <= r_ptr - PTR_W'(1);
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    // Entries are left uncleared on reset; the count gates their visibility.
    always_ff @(posedge i_clk) begin
        if (i_push && !i_reset) begin
            r_mem[r_ptr] <= i_dat;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: PC updates one edge after inputs, NEXT_PC is combinational.
// STALL freezes PC and return stack; RESET overrides STALL and any branch op.
module pc_sequencer
    import pc_defs::*;
#(
    parameter  int                  PC_WIDTH     = 32,
    parameter  int                  OFFSET_WIDTH = 8,
    parameter  int                  RAS_DEPTH    = 4,
    parameter  logic [PC_WIDTH-1:0] RESET_VECTOR = PC_WIDTH'(PC_RESET_VECTOR),
    localparam int                  CNT_W        = $clog2(RAS_DEPTH + 1)
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    STALL,
    input  logic [2:0]              BR_OP,
    input  logic                    ZERO,
    input  logic                    NEG,
    input  logic [OFFSET_WIDTH-1:0] OFFSET,
    output logic [PC_WIDTH-1:0]     PC,
    output logic [PC_WIDTH-1:0]     NEXT_PC,
    output logic [CNT_W-1:0]        RAS_COUNT,
    output logic                    RAS_OVF,
    output logic                    RAS_UNF
);

    logic [PC_WIDTH-1:0] r_pc;
    logic [PC_WIDTH-1:0] w_seq;
    logic [PC_WIDTH-1:0] w_off_ext;
    logic [PC_WIDTH-1:0] w_target;
    logic [PC_WIDTH-1:0] w_ras_top;
    logic [PC_WIDTH-1:0] w_next_pc;
    logic [CNT_W-1:0]    w_ras_count;
    logic                w_ras_ovf;
    logic                w_ras_unf;
    logic                w_taken;
    logic                w_push;
    logic                w_pop;
    br_op_e              w_op;

    assign w_op      = br_op_e'(BR_OP);
    assign w_seq     = r_pc + PC_WIDTH'(INSN_BYTES);
    assign w_off_ext = PC_WIDTH'(signed'(OFFSET));
    assign w_target  = w_seq + (w_off_ext << 2);
    assign w_taken   = br_taken(w_op, ZERO, NEG);

    always_comb begin
        w_next_pc = w_seq;
        if (w_taken) begin
            w_next_pc = w_target;
        end else if (w_op == BR_RET && w_ras_count != '0) begin
            w_next_pc = w_ras_top;
        end
    end

    assign w_push = !STALL && (w_op == BR_CALL);
    assign w_pop  = !STALL && (w_op == BR_RET);

    ras_stack #(
        .WIDTH (PC_WIDTH),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .i_clk   (CLK),
        .i_reset (RESET),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_dat   (w_seq),
        .o_top   (w_ras_top),
        .o_count (w_ras_count),
        .o_ovf   (w_ras_ovf),
        .o_unf   (w_ras_unf)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_pc <= RESET_VECTOR;
        end else if (!STALL) begin
            r_pc <= w_next_pc;
        end
    end

    assign PC        = r_pc;
    assign NEXT_PC   = w_next_pc;
    assign RAS_COUNT = w_ras_count;
    assign RAS_OVF   = w_ras_ovf;
    assign RAS_UNF   = w_ras_unf;

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter PC_WIDTH, default 32, width of PC and all address arithmetic.
REQ-002 Parameter OFFSET_WIDTH, default 8, width of signed word-offset input.
REQ-003 Parameter RAS_DEPTH, default 4, return-address-stack entries (power of two, >=2).
REQ-004 Parameter RESET_VECTOR, default 0, PC value loaded on reset.
REQ-005 CLK  input  1  clock; all state updates on rising edge.
REQ-006 RESET  input  1  synchronous, active-high reset.
REQ-007 STALL  input  1  hold PC and stack this cycle.
REQ-008 BR_OP  input  3  control op: 0 NONE, 1 JUMP, 2 BEQ, 3 BNE, 4 BLT, 5 BGE, 6 CALL, 7 RET.
REQ-009 ZERO  input  1  ALU zero flag.
REQ-010 NEG  input  1  ALU sign flag (result negative).
REQ-011 OFFSET  input  OFFSET_WIDTH  signed word offset.
REQ-012 PC  output  PC_WIDTH  current program counter, registered.
REQ-013 NEXT_PC  output  PC_WIDTH  combinational next-PC value.
REQ-014 RAS_COUNT  output  clog2(RAS_DEPTH+1)  valid stack entries.
REQ-015 RAS_OVF  output  1  sticky: a CALL overwrote an entry while stack full.
REQ-016 RAS_UNF  output  1  sticky: a RET executed while stack empty.

Function
REQ-017 SEQ = PC + 4; TARGET = SEQ + (sign-extended OFFSET << 2); all arithmetic modulo 2^PC_WIDTH.
REQ-018 Taken: JUMP always; BEQ if ZERO; BNE if !ZERO; BLT if NEG; BGE if !NEG; CALL always.
REQ-019 NEXT_PC = TARGET when taken, top-of-stack on RET with RAS_COUNT>0, else SEQ.
REQ-020 RET with RAS_COUNT==0: NEXT_PC = SEQ, RAS_UNF set, count stays 0.
REQ-021 Non-stalled, non-reset edge: PC <= NEXT_PC; single-cycle latency from inputs to PC.
REQ-022 CALL pushes SEQ; RAS_COUNT increments saturating at RAS_DEPTH.
REQ-023 CALL when RAS_COUNT==RAS_DEPTH: oldest entry overwritten (circular), count stays RAS_DEPTH, RAS_OVF set.
REQ-024 RET with RAS_COUNT>0 pops: count decrements; popped entry no longer reachable.
REQ-025 STALL=1: PC, stack contents, pointer, count, flags all unchanged; NEXT_PC still computed combinationally.
REQ-026 Sticky flags clear only on reset.
REQ-027 No delay constructs in the block; timing modelled at processor top level.

Reset
REQ-028 RESET=1 at rising edge: PC <= RESET_VECTOR, RAS_COUNT <= 0, stack pointer <= 0, RAS_OVF <= 0, RAS_UNF <= 0.
REQ-029 RESET dominates STALL and any BR_OP in the same cycle, including mid-CALL/RET sequences.
REQ-030 Stack entry contents need not be cleared on reset; unreachable while count is 0.

Structure
REQ-031 BR_OP encodings and RESET_VECTOR default reside in shared package/include pc_defs.
REQ-032 Return stack implemented as sub-module ras_stack (push, pop, top, count, ovf, unf).
REQ-033 Next-PC mux remains combinational inside pc_sequencer.

Verification
REQ-034 Reset then 3 edges BR_OP=NONE -> PC = 0, 4, 8, 12.
REQ-035 PC=0x10, BR_OP=BEQ, ZERO=1, OFFSET=-2 -> PC=0x0C; same with ZERO=0 -> PC=0x14.
REQ-036 PC=0x20, BR_OP=BLT, NEG=1, OFFSET=3 -> PC=0x30; BGE, NEG=1 -> PC=0x24.
REQ-037 PC=0x40 CALL OFFSET=8 -> PC=0x64, RAS_COUNT=1; then RET -> PC=0x44, RAS_COUNT=0.
REQ-038 Five CALLs with RAS_DEPTH=4 -> RAS_OVF=1, count=4; five RETs -> first four return newest-first, fifth gives SEQ and RAS_UNF=1.
REQ-039 STALL=1 with BR_OP=JUMP for 2 cycles -> PC unchanged; RESET asserted during STALL -> PC=RESET_VECTOR, flags and count 0.
